// File: rtl/mul_hilo_writeback.sv
// mul_hilo_writeback: captures a double-width product and writes it to HI/LO over a shared bus.
module mul_hilo_writeback #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    clear_n,
  input  logic                    prod_valid,
  input  logic [2*DATA_WIDTH-1:0] product,
  output logic                    prod_ready,
  output logic                    bus_req,
  input  logic                    bus_grant,
  output logic [DATA_WIDTH-1:0]   bus_out,
  output logic                    lo_in,
  output logic                    hi_in,
  output logic                    busy,
  output logic                    done
);
  typedef enum logic [2:0] {IDLE, REQ, WR_LO, WR_HI, DONE} state_t;
  state_t state, state_nxt;
  logic [2*DATA_WIDTH-1:0] prod_buf;
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state    <= IDLE;
      prod_buf <= '0;
    end else begin
      state <= state_nxt;
      if (prod_valid && prod_ready) prod_buf <= product;
    end
  end
  // Every output is gated by clear_n so a reset cycle is silent even mid-transfer.
  always_comb begin
    state_nxt  = state;
    prod_ready = 1'b0;
    bus_req    = 1'b0;
    bus_out    = '0;
    lo_in      = 1'b0;
    hi_in      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    state_nxt = state == IDLE  ? (prod_valid ? REQ : IDLE) :
                state == REQ   ? (bus_grant ? WR_LO : REQ) :
                state == WR_LO ? (bus_grant ? WR_HI : WR_LO) :
                state == WR_HI ? (bus_grant ? DONE : WR_HI) : IDLE;
    prod_ready = clear_n && state == IDLE;
    bus_req    = clear_n && (state == REQ || state == WR_LO || state == WR_HI);
    bus_out    = !clear_n      ? '0 :
                 state == WR_LO ? prod_buf[DATA_WIDTH-1:0] :
                 state == WR_HI ? prod_buf[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
    lo_in      = clear_n && state == WR_LO && bus_grant;
    hi_in      = clear_n && state == WR_HI && bus_grant;
    busy       = clear_n && state != IDLE;
    done       = clear_n && state == DONE;
  end
endmodule

// File: tb/tb_mul_hilo_writeback.sv
// tb_mul_hilo_writeback: directed vectors with a queue scoreboard on bus writes and done pulses.
module tb_mul_hilo_writeback;
  localparam int W = 32;
  localparam logic [1:0] K_LO = 2'd1, K_HI = 2'd2, K_DONE = 2'd3;
  logic clock = 1'b0, clear_n = 1'b0, prod_valid = 1'b0, bus_grant = 1'b0;
  logic [2*W-1:0] product = '0;
  logic prod_ready, bus_req, lo_in, hi_in, busy, done;
  logic [W-1:0] bus_out;
  typedef struct packed {logic [1:0] kind; logic [W-1:0] data;} ev_t;
  ev_t exp_q[$];
  ev_t got, want;
  int checks = 0, failures = 0;

  mul_hilo_writeback #(.DATA_WIDTH(W)) dut (
    .clock(clock), .clear_n(clear_n), .prod_valid(prod_valid), .product(product),
    .prod_ready(prod_ready), .bus_req(bus_req), .bus_grant(bus_grant), .bus_out(bus_out),
    .lo_in(lo_in), .hi_in(hi_in), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic expect_product(input logic [2*W-1:0] p, input bit with_hi);
    exp_q.push_back('{kind: K_LO, data: p[W-1:0]});
    if (with_hi) begin
      exp_q.push_back('{kind: K_HI, data: p[2*W-1:W]});
      exp_q.push_back('{kind: K_DONE, data: '0});
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Issue a single-cycle handshake; returns positioned in cycle k+1.
  task automatic handshake(input logic [2*W-1:0] p, input bit with_hi);
    product = p;
    prod_valid = 1'b1;
    expect_product(p, with_hi);
    @(negedge clock);
    chk("ready_before_hs", prod_ready, 1);
    next_cycle();
    prod_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (done) seen = 1;
    end
    chk("done_seen", seen, 1);
    next_cycle();
  endtask

  // Monitor: every bus write or done pulse must match the head of the queue.
  always @(negedge clock) begin
    if (lo_in || hi_in || done) begin
      chk("lo_hi_exclusive", lo_in & hi_in, 0);
      got.kind = lo_in ? K_LO : hi_in ? K_HI : K_DONE;
      got.data = done ? '0 : bus_out;
      if (exp_q.size() == 0) chk("unexpected_event", {30'd0, got}, 0);
      else begin
        want = exp_q.pop_front();
        chk("scoreboard_event", {30'd0, got}, {30'd0, want});
      end
    end
  end

  initial begin
    int lo_c, hi_c, dn_c, rd_c;
    // reset state
    next_cycle();
    @(negedge clock);
    chk("rst_outputs", {prod_ready, bus_req, lo_in, hi_in, busy, done, bus_out}, 0);
    next_cycle();
    clear_n = 1'b1;
    @(negedge clock);
    chk("rst_release_ready", {prod_ready, busy}, 2'b10);
    next_cycle();

    // basic writeback, grant held, product changed after capture
    bus_grant = 1'b1;
    handshake(64'hFFFF_FFFF_FFFF_FFFA, 1);
    product = 64'hDEAD_BEEF_0BAD_F00D;
    lo_c = -1; hi_c = -1; dn_c = -1; rd_c = -1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      if (lo_in && lo_c < 0) lo_c = c;
      if (hi_in && hi_c < 0) hi_c = c;
      if (done && dn_c < 0) dn_c = c;
      if (prod_ready && rd_c < 0) rd_c = c;
    end
    chk("lat_lo", lo_c, 2);
    chk("lat_hi", hi_c, 3);
    chk("lat_done", dn_c, 4);
    chk("lat_ready", rd_c, 5);
    next_cycle();

    // grant delay in REQ
    bus_grant = 1'b0;
    handshake(64'h1234_5678_9ABC_DEF0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("req_stall", {bus_req, busy, lo_in, hi_in}, 4'b1100);
      next_cycle();
    end
    bus_grant = 1'b1;
    @(negedge clock);
    chk("req_grant_edge", {bus_req, lo_in}, 2'b10);
    next_cycle();
    @(negedge clock);
    chk("lo_after_grant", {lo_in, bus_out}, {1'b1, 32'h9ABC_DEF0});
    wait_done();

    // grant drop in WR_LO for two cycles
    handshake(64'h8000_0000_7FFF_FFFF, 1);
    next_cycle();
    bus_grant = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk("wrlo_stall", {bus_req, lo_in, hi_in, bus_out}, {3'b100, 32'h7FFF_FFFF});
      next_cycle();
    end
    bus_grant = 1'b1;
    wait_done();

    // back-to-back with valid held
    product = 64'h0000_0001_0000_0002;
    prod_valid = 1'b1;
    expect_product(64'h0000_0001_0000_0002, 1);
    expect_product(64'h0000_0003_0000_0004, 1);
    next_cycle();
    product = 64'h0000_0003_0000_0004;
    rd_c = -1;
    for (int c = 1; c <= 8 && rd_c < 0; c++) begin
      @(negedge clock);
      if (prod_ready) rd_c = c;
      else next_cycle();
    end
    chk("b2b_second_accept", rd_c, 5);
    next_cycle();
    prod_valid = 1'b0;
    wait_done();

    // reset in WR_HI abandons the transfer
    handshake(64'hCAFE_F00D_1111_2222, 0);
    next_cycle();
    next_cycle();
    clear_n = 1'b0;
    @(negedge clock);
    chk("rst_in_wrhi", {prod_ready, bus_req, lo_in, hi_in, busy, done, bus_out}, 0);
    next_cycle();
    clear_n = 1'b1;
    @(negedge clock);
    chk("ready_after_rst", {prod_ready, busy}, 2'b10);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("no_done_after_rst", {done, hi_in}, 0);
    end
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mul_hilo_writeback.md
MUL_HILO_WRITEBACK -- requirements
Module: mul_hilo_writeback

Interface
REQ-001 The block SHALL have one parameter: DATA_WIDTH, default 32, width of one bus word (product is 2*DATA_WIDTH).
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 Port clock  input  1  rising-edge clock for all state.
REQ-004 Port clear_n  input  1  synchronous active-low reset.
REQ-005 Port prod_valid  input  1  multiplier product available.
REQ-006 Port product  input  2*DATA_WIDTH  signed product from the combinational Booth multiplier.
REQ-007 Port prod_ready  output  1  block can accept a product this cycle.
REQ-008 Port bus_req  output  1  request for the shared CPU bus.
REQ-009 Port bus_grant  input  1  bus arbiter grant.
REQ-010 Port bus_out  output  DATA_WIDTH  word driven onto the bus.
REQ-011 Port lo_in  output  1  LO register load enable.
REQ-012 Port hi_in  output  1  HI register load enable.
REQ-013 Port busy  output  1  writeback in progress.
REQ-014 Port done  output  1  one-cycle pulse when HI and LO have both been written.

Function
REQ-015 States SHALL be IDLE, REQ, WR_LO, WR_HI, DONE, in a registered state machine.
REQ-016 prod_ready SHALL be 1 only when state is IDLE and clear_n is 1.
REQ-017 Handshake SHALL occur on a rising edge with prod_valid and prod_ready both 1. The 2*DATA_WIDTH product is captured into an internal buffer and state goes IDLE -> REQ.
REQ-018 The buffer SHALL load only on a handshake and SHALL hold its value otherwise; product changes after capture have no effect.
REQ-019 In REQ, bus_req SHALL be 1; state goes to WR_LO on the first edge with bus_grant 1, otherwise stays.
REQ-020 In WR_LO, bus_req SHALL be 1 and bus_out SHALL be buffer[DATA_WIDTH-1:0].
  - lo_in = bus_grant (Mealy).
  - Advances to WR_HI only on an edge with bus_grant 1; otherwise stalls with lo_in 0.
REQ-021 In WR_HI, bus_req SHALL be 1 and bus_out SHALL be buffer[2*DATA_WIDTH-1:DATA_WIDTH].
  - hi_in = bus_grant.
  - Advances to DONE only on an edge with bus_grant 1; otherwise stalls with hi_in 0.
REQ-022 In DONE, done SHALL be 1, bus_req 0, and state returns to IDLE on the next edge unconditionally.
REQ-023 busy SHALL be 1 in REQ, WR_LO, WR_HI and DONE, and 0 in IDLE.
REQ-024 bus_out SHALL be 0 in IDLE, REQ and DONE; lo_in and hi_in SHALL never be 1 in the same cycle.
REQ-025 With bus_grant held at 1, latency from the handshake edge (k) SHALL be:
  - lo_in in cycle k+2;
  - hi_in in cycle k+3;
  - done in cycle k+4;
  - prod_ready again in cycle k+5.
REQ-026 prod_valid while not in IDLE SHALL be ignored (no capture, no drop flag); upstream holds prod_valid until prod_ready.
REQ-027 bus_grant in IDLE or DONE SHALL have no effect.
REQ-028 The product SHALL be passed through bit-exact (no sign or width manipulation); the full 2*DATA_WIDTH bits are split LO = low half, HI = high half.

Reset
REQ-029 On any edge with clear_n 0, in any state, the block SHALL:
  - set state to IDLE and clear the buffer to 0;
  - force bus_req, lo_in, hi_in, busy, done, bus_out and prod_ready to 0 in that cycle.
REQ-030 Reset mid-writeback (e.g. in WR_HI) SHALL abandon the transfer with no hi_in pulse and no done pulse. The first cycle after clear_n returns to 1 SHALL show prod_ready 1.

Verification
REQ-031 Basic writeback: product=64'hFFFF_FFFF_FFFF_FFFA (-6), valid 1 cycle, grant held 1 -> lo_in with bus_out=32'hFFFF_FFFA at k+2, hi_in with 32'hFFFF_FFFF at k+3, done at k+4.
REQ-032 Grant delay: grant low for 5 cycles in REQ -> bus_req held, no lo_in/hi_in, busy 1; grant rises -> lo_in next cycle.
REQ-033 Grant drop in WR_LO for 2 cycles -> lo_in 0 and bus_out=LO held, state unchanged; grant returns -> lo_in 1 then hi_in.
REQ-034 Back-to-back: valid held high with product=64'h0000_0001_0000_0002 then 64'h0000_0003_0000_0004 -> second product accepted only at k+5; writes 2,1 then 4,3; nothing lost or duplicated.
REQ-035 Reset in WR_HI -> next cycle all outputs 0; after release prod_ready 1, no done pulse.
REQ-036 Product change after capture (product driven to 64'hDEAD_BEEF_0BAD_F00D at k+1) -> bus_out still shows the captured value.
